seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial pattern detector; the next generation of the team's fixed single-pattern FSM detector.
- Samples a qualified serial bit stream and flags every occurrence of a PAT_W-bit pattern.
- Pattern is reloadable at run time; overlapping or non-overlapping match mode is selectable.
- Keeps a saturating match counter. Sits on serial control/test links as a framing/sync-word spotter.

Parameters:
- PAT_W, 4, pattern length in bits (2..32).
- PAT_RST, 4'b1011, pattern value after reset; MSB = oldest bit.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history flushed after each match.
- CNT_W, 8, width of match counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies in for this cycle.
- in  in  1  serial data bit.
- pat_load  in  1  load pat_in into the pattern register.
- pat_in  in  PAT_W  new pattern; MSB = oldest bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- out  out  1  match pulse, one cycle.
- match_cnt  out  CNT_W  saturating count of matches.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - out=0, match_cnt=0, busy=0.
  - Pattern register = PAT_RST; history = 0; fill counter = 0; state = IDLE.
  - Outputs update immediately on assertion. Deassertion is synchronous to clock at the user level.
- Sampling:
  - A bit is consumed on a rising edge only when in_valid=1.
  - History shifts left; new bit enters at LSB.
  - Cycles with in_valid=0 leave history, fill and state unchanged.
- States:
  - IDLE: no bits held. Any valid bit -> FILL, fill=1.
  - FILL: fewer than PAT_W bits held. Valid bit increments fill; when fill reaches PAT_W -> SEARCH, and that same bit is compared.
  - SEARCH: every valid bit is compared.
- Match: after the shift, the last PAT_W bits equal the pattern and fill >= PAT_W.
- Match latency:
  - out is registered. It is 1 for exactly the cycle following the edge that consumed the completing bit; otherwise 0.
  - out never stays high two cycles unless consecutive valid bits each complete a match.
- OVERLAP=1: history is kept after a match; state stays SEARCH.
- OVERLAP=0: on a match, fill := 0 and state -> IDLE. The next match needs PAT_W fresh bits.
- match_cnt:
  - Increments by 1 on each match.
  - Saturates at 2^CNT_W-1; no wrap.
- cnt_clr:
  - Sets match_cnt=0 on the next edge.
  - If a match occurs in the same cycle, clear wins: count = 0, but out still pulses.
- pat_load:
  - On the edge, pattern := pat_in, history := 0, fill := 0, state := IDLE, out := 0.
  - A valid bit presented in the same cycle is discarded.
  - pat_load has priority over sampling; match_cnt is unaffected.
- Simultaneous pat_load and cnt_clr: both take effect.
- Reset mid-stream: partially accumulated bits are lost; detection restarts from IDLE with PAT_RST.
- busy = (state != IDLE).

Test Plan:
- Default params, reset held 2 cycles then released; in_valid=1 on each cycle with bits 1,0,1,1 -> out=0 through the 4th edge, out=1 the cycle after the 4th edge, match_cnt=1, busy=1.
- OVERLAP=1, stream 1,0,1,1,0,1,1 -> out pulses after bits 4 and 7, match_cnt=2.
- OVERLAP=0, same stream -> single pulse after bit 4, match_cnt=1, busy=0 after the match.
- Stream 1,0,1,1 with in_valid=0 gaps of 3 cycles between bits (in toggled randomly during gaps) -> exactly one pulse, after the edge of the final valid bit.
- pat_load with pat_in=4'b0110, then stream 0,1,1,0 -> one match. Then pat_load asserted with in_valid=1 in the same cycle -> that bit is ignored and busy=0.
- CNT_W=2, 5 overlapping matches of 4'b1111 (stream of eight 1s) -> match_cnt saturates at 3. cnt_clr in the same cycle as a completing bit -> match_cnt=0 and out=1. reset pulled low mid-pattern -> out=0 and match_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time reloadable pattern,
// selectable overlapping/non-overlapping matching and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SEARCH = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PAT_W-1:0]   pattern, pattern_nxt;
    logic [PAT_W-1:0]   hist, hist_nxt, shifted;
    logic [FILL_W-1:0]  fill, fill_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               out_nxt;
    logic               busy_nxt;
    logic               match;

    // State, history, pattern and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pattern   <= PAT_RST;
            hist      <= '0;
            fill      <= '0;
            out       <= 1'b0;
            match_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pattern   <= pattern_nxt;
            hist      <= hist_nxt;
            fill      <= fill_nxt;
            out       <= out_nxt;
            match_cnt <= cnt_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state: pattern reload beats sampling; a completing bit is compared in the same cycle.
    always_comb begin
        state_nxt   = state;
        pattern_nxt = pattern;
        hist_nxt    = hist;
        fill_nxt    = fill;
        cnt_nxt     = match_cnt;
        out_nxt     = 1'b0;
        match       = 1'b0;
        shifted     = {hist[PAT_W-2:0], in};

        if (pat_load) begin
            pattern_nxt = pat_in;
            hist_nxt    = '0;
            fill_nxt    = '0;
            state_nxt   = IDLE;
        end else if (in_valid) begin
            hist_nxt = shifted;
            unique case (state)
                IDLE: begin
                    fill_nxt  = FILL_W'(1);
                    state_nxt = FILL;
                end
                FILL: begin
                    fill_nxt = fill + FILL_W'(1);
                    if (fill_nxt == FILL_W'(PAT_W)) begin
                        state_nxt = SEARCH;
                        match     = (shifted == pattern);
                    end
                end
                SEARCH: begin
                    match = (shifted == pattern);
                end
                default: begin
                    state_nxt = IDLE;
                    fill_nxt  = '0;
                end
            endcase
            // Non-overlapping mode: the next match needs a full set of fresh bits.
            if (match && !OVERLAP) begin
                fill_nxt  = '0;
                hist_nxt  = '0;
                state_nxt = IDLE;
            end
        end

        out_nxt = match;

        if (cnt_clr) begin
            cnt_nxt = '0;
        end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
            cnt_nxt = match_cnt + CNT_W'(1);
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlap/cnt8, non-overlap/cnt8,
// overlap/cnt2) driven one at a time against a behavioural scoreboard.
module tb_seq_detect_param;

    logic       clock;
    logic       reset;
    logic       iv [3];
    logic       ib [3];
    logic       pl [3];
    logic [3:0] pi [3];
    logic       cc [3];
    logic       o  [3];
    logic       bz [3];
    logic [7:0] c  [3];
    logic [7:0] c0, c1;
    logic [1:0] c2;

    typedef struct {
        int   idx;
        logic out;
        int   cnt;
        logic busy;
    } exp_t;

    exp_t       sbq [$];
    logic [3:0] m_hist [3];
    logic [3:0] m_pat  [3];
    int         m_fill [3];
    int         m_cnt  [3];
    int         m_max  [3];
    bit         m_ovl  [3];

    int n_checks;
    int n_fail;

    seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in(ib[0]), .pat_load(pl[0]),
        .pat_in(pi[0]), .cnt_clr(cc[0]), .out(o[0]), .match_cnt(c0), .busy(bz[0]));
    seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in(ib[1]), .pat_load(pl[1]),
        .pat_in(pi[1]), .cnt_clr(cc[1]), .out(o[1]), .match_cnt(c1), .busy(bz[1]));
    seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u2 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in(ib[2]), .pat_load(pl[2]),
        .pat_in(pi[2]), .cnt_clr(cc[2]), .out(o[2]), .match_cnt(c2), .busy(bz[2]));

    assign c[0] = c0;
    assign c[1] = c1;
    assign c[2] = {6'b0, c2};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    // Reference model back to the reset state.
    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_hist[d] = 4'b0;
            m_pat[d]  = 4'b1011;
            m_fill[d] = 0;
            m_cnt[d]  = 0;
        end
    endtask

    // Drive one cycle on instance d, update the model and queue the expected result.
    task automatic drive(input int d, input logic v, input logic b, input logic load,
                         input logic [3:0] pin, input logic clr);
        exp_t e;
        logic m;
        @(negedge clock);
        iv[d] = v; ib[d] = b; pl[d] = load; pi[d] = pin; cc[d] = clr;
        m = 1'b0;
        if (load) begin
            m_pat[d]  = pin;
            m_hist[d] = 4'b0;
            m_fill[d] = 0;
        end else if (v) begin
            m_hist[d] = {m_hist[d][2:0], b};
            if (m_fill[d] < 4) m_fill[d]++;
            m = (m_fill[d] >= 4) && (m_hist[d] == m_pat[d]);
            if (m && !m_ovl[d]) begin
                m_fill[d] = 0;
                m_hist[d] = 4'b0;
            end
        end
        if (clr) m_cnt[d] = 0;
        else if (m && m_cnt[d] < m_max[d]) m_cnt[d]++;
        e.idx = d; e.out = m; e.cnt = m_cnt[d]; e.busy = (m_fill[d] != 0);
        sbq.push_back(e);
        @(posedge clock);
        #1;
        iv[d] = 1'b0; pl[d] = 1'b0; cc[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (o[d] !== 1'b0 || c[d] !== 8'd0 || bz[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got out=%b cnt=%0d busy=%b, want out=0 cnt=0 busy=0",
                         d, o[d], c[d], bz[d]);
            end
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        exp_t e;
        logic [3:0] s = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, s[3-i], 1'b0, 4'b0, 1'b0);
            e = sbq.pop_front();
            n_checks++;
            if (o[e.idx] !== e.out || c[e.idx] !== 8'(e.cnt) || bz[e.idx] !== e.busy) begin
                n_fail++;
                $display("FAIL basic[%0d]: got out=%b cnt=%0d busy=%b, want out=%b cnt=%0d busy=%b",
                         i, o[e.idx], c[e.idx], bz[e.idx], e.out, e.cnt, e.busy);
            end
        end
        n_checks++;
        if (o[0] !== 1'b1 || c[0] !== 8'd1 || bz[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_final: got out=%b cnt=%0d busy=%b, want out=1 cnt=1 busy=1",
                     o[0], c[0], bz[0]);
        end
    endtask

    task automatic test_overlap();
        exp_t e;
        logic [6:0] s = 7'b1011011;
        int pulses = 0;
        drive(0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
        e = sbq.pop_front();
        n_checks++;
        if (o[e.idx] !== e.out || c[e.idx] !== 8'(e.cnt) || bz[e.idx] !== e.busy) begin
            n_fail++;
            $display("FAIL overlap_load: got out=%b cnt=%0d busy=%b, want out=%b cnt=%0d busy=%b",
                     o[e.idx], c[e.idx], bz[e.idx], e.out, e.cnt, e.busy);
        end
        for (int i = 0; i < 7; i++) begin
            drive(0, 1'b1, s[6-i], 1'b0, 4'b0, 1'b0);
            e = sbq.pop_front();
            if (o[0] === 1'b1) pulses++;
            n_checks++;
            if (o[e.idx] !== e.out || c[e.idx] !== 8'(e.cnt) || bz[e.idx] !== e.busy) begin
                n_fail++;
                $display("FAIL overlap[%0d]: got out=%b cnt=%0d busy=%b, want out=%b cnt=%0d busy=%b",
                         i, o[e.idx], c[e.idx], bz[e.idx], e.out, e.cnt, e.busy);
            end
        end
        n_checks++;
        if (pulses != 2 || c[0] !== 8'd3) begin
            n_fail++;
            $display("FAIL overlap_total: got pulses=%0d cnt=%0d, want pulses=2 cnt=3", pulses, c[0]);
        end
    endtask

    task automatic test_nonoverlap();
        exp_t e;
        logic [6:0] s = 7'b1011011;
        int pulses = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1, 1'b1, s[6-i], 1'b0, 4'b0, 1'b0);
            e = sbq.pop_front();
            if (o[1] === 1'b1) pulses++;
            n_checks++;
            if (o[e.idx] !== e.out || c[e.idx] !== 8'(e.cnt) || bz[e.idx] !== e.busy) begin
                n_fail++;
                $display("FAIL nonoverlap[%0d]: got out=%b cnt=%0d busy=%b, want out=%b cnt=%0d busy=%b",
                         i, o[e.idx], c[e.idx], bz[e.idx], e.out, e.cnt, e.busy);
            end
            if (i == 3) begin
                n_checks++;
                if (o[1] !== 1'b1 || bz[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nonoverlap_idle: got out=%b busy=%b, want out=1 busy=0", o[1], bz[1]);
                end
            end
        end
        n_checks++;
        if (pulses != 1 || c[1] !== 8'd1) begin
            n_fail++;
            $display("FAIL nonoverlap_total: got pulses=%0d cnt=%0d, want pulses=1 cnt=1", pulses, c[1]);
        end
    endtask

    task automatic test_gaps();
        exp_t e;
        logic [3:0] s = 4'b1011;
        int pulses = 0;
        drive(1, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
        void'(sbq.pop_front());
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 4; g++) begin
                if (g == 0) drive(1, 1'b1, s[3-i], 1'b0, 4'b0, 1'b0);
                else        drive(1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'b0, 1'b0);
                e = sbq.pop_front();
                if (o[1] === 1'b1) pulses++;
                n_checks++;
                if (o[e.idx] !== e.out || c[e.idx] !== 8'(e.cnt) || bz[e.idx] !== e.busy) begin
                    n_fail++;
                    $display("FAIL gaps[%0d.%0d]: got out=%b cnt=%0d busy=%b, want out=%b cnt=%0d busy=%b",
                             i, g, o[e.idx], c[e.idx], bz[e.idx], e.out, e.cnt, e.busy);
                end
            end
        end
        n_checks++;
        if (pulses != 1 || c[1] !== 8'd2) begin
            n_fail++;
            $display("FAIL gaps_total: got pulses=%0d cnt=%0d, want pulses=1 cnt=2", pulses, c[1]);
        end
    endtask

    task automatic test_pat_load();
        exp_t e;
        logic [3:0] s = 4'b0110;
        drive(0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0);
        void'(sbq.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, s[3-i], 1'b0, 4'b0, 1'b0);
            e = sbq.pop_front();
            n_checks++;
            if (o[e.idx] !== e.out || c[e.idx] !== 8'(e.cnt) || bz[e.idx] !== e.busy) begin
                n_fail++;
                $display("FAIL patload[%0d]: got out=%b cnt=%0d busy=%b, want out=%b cnt=%0d busy=%b",
                         i, o[e.idx], c[e.idx], bz[e.idx], e.out, e.cnt, e.busy);
            end
        end
        // Valid bit alongside pat_load must be discarded.
        drive(0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
        e = sbq.pop_front();
        n_checks++;
        if (o[0] !== 1'b0 || bz[0] !== 1'b0 || c[0] !== 8'd4 || c[0] !== 8'(e.cnt)) begin
            n_fail++;
            $display("FAIL patload_valid: got out=%b cnt=%0d busy=%b, want out=0 cnt=4 busy=0",
                     o[0], c[0], bz[0]);
        end
        // pat_load together with cnt_clr: both apply.
        drive(0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
        e = sbq.pop_front();
        n_checks++;
        if (o[0] !== 1'b0 || bz[0] !== 1'b0 || c[0] !== 8'd0 || c[0] !== 8'(e.cnt)) begin
            n_fail++;
            $display("FAIL patload_clr: got out=%b cnt=%0d busy=%b, want out=0 cnt=0 busy=0",
                     o[0], c[0], bz[0]);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        drive(2, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
        void'(sbq.pop_front());
        for (int i = 0; i < 10; i++) begin
            drive(2, 1'b1, 1'b1, 1'b0, 4'b0, (i == 8) ? 1'b1 : 1'b0);
            e = sbq.pop_front();
            n_checks++;
            if (o[e.idx] !== e.out || c[e.idx] !== 8'(e.cnt) || bz[e.idx] !== e.busy) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got out=%b cnt=%0d busy=%b, want out=%b cnt=%0d busy=%b",
                         i, o[e.idx], c[e.idx], bz[e.idx], e.out, e.cnt, e.busy);
            end
            if (i == 7) begin
                n_checks++;
                if (c[2] !== 8'd3) begin
                    n_fail++;
                    $display("FAIL saturate_max: got cnt=%0d, want cnt=3", c[2]);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (o[2] !== 1'b1 || c[2] !== 8'd0) begin
                    n_fail++;
                    $display("FAIL clr_wins: got out=%b cnt=%0d, want out=1 cnt=0", o[2], c[2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [3:0] s = 4'b1011;
        // out is high and counts are nonzero here; reset must clear without a clock edge.
        #1;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d += 2) begin
            n_checks++;
            if (o[d] !== 1'b0 || c[d] !== 8'd0 || bz[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got out=%b cnt=%0d busy=%b, want out=0 cnt=0 busy=0",
                         d, o[d], c[d], bz[d]);
            end
        end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(2, 1'b1, s[3-i], 1'b0, 4'b0, 1'b0);
            e = sbq.pop_front();
            n_checks++;
            if (o[e.idx] !== e.out || c[e.idx] !== 8'(e.cnt) || bz[e.idx] !== e.busy) begin
                n_fail++;
                $display("FAIL reset_restart[%0d]: got out=%b cnt=%0d busy=%b, want out=%b cnt=%0d busy=%b",
                         i, o[e.idx], c[e.idx], bz[e.idx], e.out, e.cnt, e.busy);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ib[d] = 1'b0; pl[d] = 1'b0; pi[d] = 4'b0; cc[d] = 1'b0;
        end
        m_max[0] = 255; m_max[1] = 255; m_max[2] = 3;
        m_ovl[0] = 1'b1; m_ovl[1] = 1'b0; m_ovl[2] = 1'b1;
        model_reset();

        test_reset();
        test_basic();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_pat_load();
        test_saturate();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
